// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency ROM and hands
// {pc, instr} pairs to decode through a bypass path plus a 2-entry skid FIFO.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_pc,
    output logic [DATA_WIDTH-1:0] out_instr
);

    logic [31:0]           pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [31:0]           inflight_pc_q, inflight_pc_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [31:0]           fifo_pc_q    [2];
    logic [DATA_WIDTH-1:0] fifo_instr_q [2];

    logic       head_valid;
    logic       pop;
    logic       fifo_pop;
    logic       push;
    logic       issue;
    logic       wr_ptr;
    logic [2:0] occupancy;

    assign rom_addr = pc_q[ADDR_WIDTH+1:2];

    always_comb begin
        head_valid = (count_q != 2'd0);
        out_valid  = head_valid || inflight_q;
        out_pc     = head_valid ? fifo_pc_q[rd_ptr_q]    : inflight_pc_q;
        out_instr  = head_valid ? fifo_instr_q[rd_ptr_q] : rom_q;
        pop        = out_valid && out_ready;
        fifo_pop   = pop && head_valid;
        // The arriving word is only buffered when decode is not taking it via bypass.
        push       = inflight_q && !(!head_valid && out_ready);
        wr_ptr     = rd_ptr_q ^ count_q[0];
        occupancy  = {1'b0, count_q} + {2'b00, inflight_q};
        issue      = !redirect_valid && ((occupancy < 3'd2) || pop);
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q + 2'(push) - 2'(fifo_pop);
        rd_ptr_d      = fifo_pop ? ~rd_ptr_q : rd_ptr_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc & ~32'h3;
            inflight_d = 1'b0;
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
        end else if (issue) begin
            inflight_pc_d = pc_q;
            pc_d          = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset; count_q alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr]    <= inflight_pc_q;
            fifo_instr_q[wr_ptr] <= rom_q;
        end
    end

endmodule
